video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_if.sv | 29 ++
 rtl/video_timing_gen.sv | 111 +++++++++++
 2 files changed

// File: rtl/video_timing_if.sv
// Pixel-request and video-output bundle between video_timing_gen and its pattern source / encoder.
// VIDEO_TIMING_FRAME_CNT_EN adds frame_cnt/frame_start.
interface video_timing_if #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
);
    logic [X_BITS-1:0] pix_x;
    logic [Y_BITS-1:0] pix_y;
    logic              pix_req;
    logic [23:0]       pix_data;
    logic              hs_out;
    logic              vs_out;
    logic              de_out;
    logic [23:0]       rgb_out;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
    logic              frame_start;

    modport master (output pix_x, pix_y, pix_req, hs_out, vs_out, de_out, rgb_out,
                     frame_cnt, frame_start, input pix_data);
    modport slave  (input pix_x, pix_y, pix_req, hs_out, vs_out, de_out, rgb_out,
                    frame_cnt, frame_start, output pix_data);
`else
    modport master (output pix_x, pix_y, pix_req, hs_out, vs_out, de_out, rgb_out,
                    input pix_data);
    modport slave  (input pix_x, pix_y, pix_req, hs_out, vs_out, de_out, rgb_out,
                    output pix_data);
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel requests to a pattern source, syncs/DE aligned with returned RGB.
// Optional macro VIDEO_TIMING_FRAME_CNT_EN adds a frame counter and first-pixel frame_start pulse.
module video_timing_gen #(
    parameter int   X_BITS  = 12,
    parameter int   Y_BITS  = 12,
    parameter int   H_SYNC  = 44,
    parameter int   H_BACK  = 148,
    parameter int   H_DISP  = 1920,
    parameter int   H_FRONT = 88,
    parameter int   V_SYNC  = 5,
    parameter int   V_BACK  = 36,
    parameter int   V_DISP  = 1080,
    parameter int   V_FRONT = 4,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1
) (
    input  logic           i_pix_clk,
    input  logic           i_rst_n,
    video_timing_if.master vid
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int STAGES  = 2;

    localparam logic [X_BITS-1:0] H_LAST  = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_SYN_E = X_BITS'(H_SYNC);
    localparam logic [X_BITS-1:0] H_ACT_S = X_BITS'(H_SYNC + H_BACK);
    localparam logic [X_BITS-1:0] H_ACT_E = X_BITS'(H_SYNC + H_BACK + H_DISP);
    localparam logic [Y_BITS-1:0] V_LAST  = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_SYN_E = Y_BITS'(V_SYNC);
    localparam logic [Y_BITS-1:0] V_ACT_S = Y_BITS'(V_SYNC + V_BACK);
    localparam logic [Y_BITS-1:0] V_ACT_E = Y_BITS'(V_SYNC + V_BACK + V_DISP);

    logic [X_BITS-1:0] r_h_cnt;
    logic [Y_BITS-1:0] r_v_cnt;
    logic [X_BITS-1:0] r_pix_x;
    logic [Y_BITS-1:0] r_pix_y;
    logic [STAGES:0]   r_vld_pipe;
    logic [STAGES:0]   r_hs_pipe;
    logic [STAGES:0]   r_vs_pipe;
    logic [23:0]       r_rgb;
    logic              w_h_wrap, w_v_wrap, w_active, w_hs, w_vs;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_active = (r_h_cnt >= H_ACT_S) && (r_h_cnt < H_ACT_E) &&
                      (r_v_cnt >= V_ACT_S) && (r_v_cnt < V_ACT_E);
    assign w_hs     = (r_h_cnt < H_SYN_E);
    // vsync follows v_cnt only, so its edges land on h_cnt = 0 by construction
    assign w_vs     = (r_v_cnt < V_SYN_E);

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + X_BITS'(1);
            if (w_h_wrap)
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + Y_BITS'(1);
        end
    end

    // stage 0 is the request register; stage 1 carries pix_data arrival; stage 2 drives the outputs
    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            r_pix_x    <= '0;
            r_pix_y    <= '0;
            r_vld_pipe <= '0;
            r_hs_pipe  <= '0;
            r_vs_pipe  <= '0;
            r_rgb      <= '0;
        end else begin
            r_pix_x    <= w_active ? r_h_cnt - H_ACT_S : '0;
            r_pix_y    <= w_active ? r_v_cnt - V_ACT_S : '0;
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_active};
            r_hs_pipe  <= {r_hs_pipe[STAGES-1:0], w_hs};
            r_vs_pipe  <= {r_vs_pipe[STAGES-1:0], w_vs};
            r_rgb      <= r_vld_pipe[STAGES-1] ? vid.pix_data : 24'd0;
        end
    end

    assign vid.pix_x   = r_pix_x;
    assign vid.pix_y   = r_pix_y;
    assign vid.pix_req = r_vld_pipe[0];
    assign vid.de_out  = r_vld_pipe[STAGES];
    assign vid.rgb_out = r_rgb;
    assign vid.hs_out  = r_hs_pipe[STAGES] ? HS_POL : ~HS_POL;
    assign vid.vs_out  = r_vs_pipe[STAGES] ? VS_POL : ~VS_POL;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0]     r_frame_cnt;
    logic [STAGES:0] r_fs_pipe;
    logic            w_first;

    assign w_first = (r_h_cnt == H_ACT_S) && (r_v_cnt == V_ACT_S);

    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
            r_fs_pipe   <= '0;
        end else begin
            if (w_h_wrap && w_v_wrap)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            r_fs_pipe <= {r_fs_pipe[STAGES-1:0], w_first};
        end
    end

    assign vid.frame_cnt   = r_frame_cnt;
    assign vid.frame_start = r_fs_pipe[STAGES];
`endif
endmodule
